// File: rtl/npu_pkg.sv
// Shared NPU definitions: row-controller state encoding, default image
// height and class width. Also imported by the AHB CSR decoder.
package npu_pkg;

  localparam int unsigned IMG_ROWS_DEFAULT = 28;
  localparam int unsigned ROW_W            = 6;
  localparam int unsigned CLASS_W          = 5;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } row_ctrl_state_t;

endpackage

// File: rtl/npu_row_ctrl.sv
// npu_row_ctrl: tracks image rows written by the CSR path, starts the NPU
// core once enough rows are present, and latches the core's result.
//
// Ports:
//   clk                           rising-edge clock
//   resetn                        asynchronous active-low reset
//   write_row                     pulse: one image row written
//   npu_thrshld_num_rows_to_start rows required before core start
//   core_done / core_class        pulse + class from the core
//   core_row_req / core_row_ready row the core needs / row is present
//   npu_start                     one-cycle start pulse to the core
//   img_num_rows_written          rows written for the current image
//   npu_active                    core running
//   npu_done                      sticky done flag
//   npu_class_predicted           class latched at done
//   row_overflow_lat_r            sticky: row written beyond IMG_ROWS
module npu_row_ctrl
  import npu_pkg::*;
#(
  parameter int unsigned IMG_ROWS = IMG_ROWS_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               write_row,
  input  logic [ROW_W-1:0]   npu_thrshld_num_rows_to_start,
  input  logic               core_done,
  input  logic [CLASS_W-1:0] core_class,
  input  logic [ROW_W-1:0]   core_row_req,
  output logic               core_row_ready,
  output logic               npu_start,
  output logic [ROW_W-1:0]   img_num_rows_written,
  output logic               npu_active,
  output logic               npu_done,
  output logic [CLASS_W-1:0] npu_class_predicted,
  output logic               row_overflow_lat_r
);

  localparam logic [ROW_W-1:0] ROWS_MAX = ROW_W'(IMG_ROWS);

  // Zero or an out-of-range threshold means "wait for the full image".
  function automatic logic [ROW_W-1:0] thr_clamp(input logic [ROW_W-1:0] thr);
    if (thr == '0 || thr > ROWS_MAX) return ROWS_MAX;
    else                             return thr;
  endfunction

  row_ctrl_state_t  state, state_n;
  logic [ROW_W-1:0] count;
  logic [ROW_W-1:0] thr_eff;
  logic             thr_met;

  assign thr_eff = thr_clamp(npu_thrshld_num_rows_to_start);
  // Only consulted in FILL, so threshold changes elsewhere are inert.
  assign thr_met = (state == FILL) && (count >= thr_eff);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (write_row) state_n = FILL;
      FILL:    if (thr_met)   state_n = RUN;
      RUN:     if (core_done) state_n = DONE;
      DONE:    if (write_row) state_n = FILL;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count               <= '0;
      npu_start           <= 1'b0;
      npu_done            <= 1'b0;
      npu_class_predicted <= '0;
      row_overflow_lat_r  <= 1'b0;
    end else begin
      // Leaving FILL on the same edge keeps the pulse one cycle wide.
      npu_start <= thr_met;
      if (write_row) begin
        if (state == IDLE || state == DONE) begin
          count              <= ROW_W'(1);
          npu_done           <= 1'b0;
          row_overflow_lat_r <= 1'b0;
        end else if (count < ROWS_MAX) begin
          count <= count + ROW_W'(1);
        end else begin
          row_overflow_lat_r <= 1'b1;
        end
      end
      if (state == RUN && core_done) begin
        npu_done            <= 1'b1;
        npu_class_predicted <= core_class;
      end
    end
  end

  always_comb begin
    core_row_ready = 1'b0;
    unique case (state)
      FILL, RUN: core_row_ready = (core_row_req < count);
      DONE:      core_row_ready = 1'b1;
      default:   core_row_ready = 1'b0;
    endcase
  end

  assign npu_active           = (state == RUN);
  assign img_num_rows_written = count;

endmodule

// File: tb/tb_npu_row_ctrl.sv
// Directed bench for npu_row_ctrl with a cycle model feeding a scoreboard.
module tb_npu_row_ctrl;
  import npu_pkg::*;

  localparam int unsigned R = 28;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       write_row = 1'b0;
  logic [5:0] thr = '0;
  logic       core_done = 1'b0;
  logic [4:0] core_class = '0;
  logic [5:0] req = '0;
  logic       core_row_ready;
  logic       npu_start;
  logic [5:0] img_num_rows_written;
  logic       npu_active;
  logic       npu_done;
  logic [4:0] npu_class_predicted;
  logic       row_overflow_lat_r;

  npu_row_ctrl #(.IMG_ROWS(R)) dut (
    .clk                           (clk),
    .resetn                        (resetn),
    .write_row                     (write_row),
    .npu_thrshld_num_rows_to_start (thr),
    .core_done                     (core_done),
    .core_class                    (core_class),
    .core_row_req                  (req),
    .core_row_ready                (core_row_ready),
    .npu_start                     (npu_start),
    .img_num_rows_written          (img_num_rows_written),
    .npu_active                    (npu_active),
    .npu_done                      (npu_done),
    .npu_class_predicted           (npu_class_predicted),
    .row_overflow_lat_r            (row_overflow_lat_r)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] count;
    logic       start;
    logic       active;
    logic       done;
    logic [4:0] cls;
    logic       ovf;
    logic       ready;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  row_ctrl_state_t m_state = IDLE;
  logic [5:0]      m_count = '0;
  logic            m_done  = 1'b0;
  logic [4:0]      m_cls   = '0;
  logic            m_ovf   = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of pulses, predict the post-edge outputs, then compare.
  task automatic step(input logic wr, input logic cd, input logic [4:0] cls);
    exp_t            e;
    logic [5:0]      te;
    row_ctrl_state_t n_state;
    logic [5:0]      n_count;
    logic            n_done, n_ovf, n_start;
    logic [4:0]      n_cls;
    write_row  = wr;
    core_done  = cd;
    core_class = cls;
    te = (thr == 6'd0 || thr > 6'(R)) ? 6'(R) : thr;
    n_state = m_state; n_count = m_count; n_done = m_done;
    n_cls = m_cls; n_ovf = m_ovf;
    n_start = (m_state == FILL) && (m_count >= te);
    case (m_state)
      IDLE, DONE: if (wr) begin
        n_count = 6'd1; n_done = 1'b0; n_ovf = 1'b0; n_state = FILL;
      end
      default: begin
        if (wr) begin
          if (m_count < 6'(R)) n_count = m_count + 6'd1;
          else                 n_ovf = 1'b1;
        end
        if (m_state == FILL && m_count >= te) n_state = RUN;
        if (m_state == RUN && cd) begin
          n_state = DONE; n_done = 1'b1; n_cls = cls;
        end
      end
    endcase
    m_state = n_state; m_count = n_count; m_done = n_done;
    m_cls = n_cls; m_ovf = n_ovf;
    e.count  = n_count;
    e.start  = n_start;
    e.active = (n_state == RUN);
    e.done   = n_done;
    e.cls    = n_cls;
    e.ovf    = n_ovf;
    e.ready  = (n_state == DONE) ? 1'b1 :
               (n_state == IDLE) ? 1'b0 : (req < n_count);
    sb.push_back(e);
    @(posedge clk);
    #1;
    write_row = 1'b0;
    core_done = 1'b0;
    e = sb.pop_front();
    chk("count",  8'(img_num_rows_written), 8'(e.count));
    chk("start",  8'(npu_start),            8'(e.start));
    chk("active", 8'(npu_active),           8'(e.active));
    chk("done",   8'(npu_done),             8'(e.done));
    chk("class",  8'(npu_class_predicted),  8'(e.cls));
    chk("ovf",    8'(row_overflow_lat_r),   8'(e.ovf));
    chk("ready",  8'(core_row_ready),       8'(e.ready));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"},  8'(img_num_rows_written), 8'd0);
    chk({tag, "_start"},  8'(npu_start),            8'd0);
    chk({tag, "_active"}, 8'(npu_active),           8'd0);
    chk({tag, "_done"},   8'(npu_done),             8'd0);
    chk({tag, "_class"},  8'(npu_class_predicted),  8'd0);
    chk({tag, "_ovf"},    8'(row_overflow_lat_r),   8'd0);
    chk({tag, "_ready"},  8'(core_row_ready),       8'd0);
  endtask

  task automatic model_reset();
    m_state = IDLE; m_count = '0; m_done = 1'b0; m_cls = '0; m_ovf = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset
    #12;
    check_reset_outputs("por");
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    // Image A: threshold 3, rows one idle cycle apart
    thr = 6'd3; req = 6'd0;
    step(1, 0, 0); chk("a_cnt1", 8'(img_num_rows_written), 8'd1);
    step(0, 0, 0);
    step(1, 0, 0); chk("a_cnt2", 8'(img_num_rows_written), 8'd2);
    step(0, 0, 0);
    step(1, 0, 0); chk("a_cnt3", 8'(img_num_rows_written), 8'd3);
    chk("a_nostart_edge1", 8'(npu_start), 8'd0);
    step(0, 0, 0); chk("a_start_edge2", 8'(npu_start), 8'd1);
    chk("a_active", 8'(npu_active), 8'd1);
    thr = 6'd1;  // ignored while running
    step(0, 0, 0); chk("a_start_once", 8'(npu_start), 8'd0);
    req = 6'd2; step(0, 0, 0); chk("a_ready_req2", 8'(core_row_ready), 8'd1);
    req = 6'd3; step(0, 0, 0); chk("a_ready_req3", 8'(core_row_ready), 8'd0);
    // Done and row write in the same cycle
    step(1, 1, 5'd17);
    chk("a_done", 8'(npu_done), 8'd1);
    chk("a_class17", 8'(npu_class_predicted), 8'd17);
    chk("a_cnt4", 8'(img_num_rows_written), 8'd4);
    step(0, 1, 5'd9); chk("a_class_hold", 8'(npu_class_predicted), 8'd17);

    // Image B: threshold 0 -> full image; ready boundary at row 5
    thr = 6'd0; req = 6'd5;
    for (int i = 1; i <= 28; i++) begin
      step(1, 0, 0);
      if (i == 1) chk("b_done_clr", 8'(npu_done), 8'd0);
      if (i == 5) chk("b_ready_at5", 8'(core_row_ready), 8'd0);
      if (i == 6) chk("b_ready_at6", 8'(core_row_ready), 8'd1);
    end
    chk("b_class_kept", 8'(npu_class_predicted), 8'd17);
    step(0, 0, 0); chk("b_start", 8'(npu_start), 8'd1);
    step(1, 0, 0); chk("b_ovf", 8'(row_overflow_lat_r), 8'd1);
    chk("b_cnt_sat", 8'(img_num_rows_written), 8'd28);
    step(0, 1, 5'd3);

    // Image C: threshold 40 behaves like full image
    thr = 6'd40; req = 6'd0;
    for (int i = 1; i <= 28; i++) step(1, 0, 0);
    step(0, 0, 0); chk("c_start", 8'(npu_start), 8'd1);
    step(0, 1, 5'd11); chk("c_class", 8'(npu_class_predicted), 8'd11);

    // Image D: threshold 28, 29 back-to-back rows
    thr = 6'd28;
    for (int i = 1; i <= 29; i++) step(1, 0, 0);
    chk("d_cnt28", 8'(img_num_rows_written), 8'd28);
    chk("d_ovf", 8'(row_overflow_lat_r), 8'd1);
    step(0, 0, 0);
    step(0, 1, 5'd5);
    step(1, 0, 0); chk("d_ovf_clr", 8'(row_overflow_lat_r), 8'd0);
    chk("d_new_cnt", 8'(img_num_rows_written), 8'd1);

    // Image E: reset while running with 10 rows
    thr = 6'd10; req = 6'd3;
    for (int i = 2; i <= 10; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("e_active", 8'(npu_active), 8'd1);
    chk("e_cnt10", 8'(img_num_rows_written), 8'd10);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_run_rst");
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    step(0, 1, 5'd7); chk("e_done_ignored", 8'(npu_done), 8'd0);
    step(0, 0, 0);    chk("e_no_start", 8'(npu_start), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/npu_row_ctrl.md
NPU_ROW_CTRL -- requirements
Module: npu_row_ctrl

Interface
REQ-001 SHALL have parameter IMG_ROWS, default 28, rows per input image (1..63).
REQ-002 SHALL have input clk, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have input resetn, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input write_row, 1 bit: one-cycle pulse from the AHB CSR decoder; one image row has been written to image memory.
REQ-005 SHALL have input npu_thrshld_num_rows_to_start, 6 bits: rows required before the NPU core starts.
REQ-006 SHALL have input core_done, 1 bit: one-cycle pulse from the NPU core; inference finished.
REQ-007 SHALL have input core_class, 5 bits: predicted class, valid with core_done.
REQ-008 SHALL have input core_row_req, 6 bits: row index the core needs next.
REQ-009 SHALL have output core_row_ready, 1 bit: the requested row is present.
REQ-010 SHALL have output npu_start, 1 bit: one-cycle start pulse to the core.
REQ-011 SHALL have output img_num_rows_written, 6 bits: rows written for the current image.
REQ-012 SHALL have output npu_active, 1 bit: the core is running.
REQ-013 SHALL have output npu_done, 1 bit: sticky done flag for the CSR.
REQ-014 SHALL have output npu_class_predicted, 5 bits: class latched at done.
REQ-015 SHALL have output row_overflow_lat_r, 1 bit: sticky flag; a row was written beyond IMG_ROWS.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, FILL, RUN, DONE.
REQ-017 SHALL compute the effective threshold thr_eff: 0 or any value >IMG_ROWS becomes IMG_ROWS; otherwise the input value is used unchanged.
REQ-018 SHALL, on write_row in IDLE, set count to 1, enter FILL, and clear npu_done and row_overflow_lat_r.
REQ-019 SHALL, on write_row in FILL or RUN with count<IMG_ROWS, increment count by 1 at the next edge.
REQ-020 SHALL, on write_row in FILL or RUN with count==IMG_ROWS, hold count and set row_overflow_lat_r.
REQ-021 SHALL, in FILL with registered count>=thr_eff, drive npu_start=1 for exactly one cycle at the next edge and enter RUN on that same edge.
REQ-022 SHALL, as a consequence of REQ-021, assert npu_start two edges after the write_row that makes count reach threshold.
REQ-023 SHALL sample thr_eff only in FILL; threshold changes in RUN or DONE have no effect.
REQ-024 SHALL drive npu_active=1 exactly while in RUN.
REQ-025 SHALL, on core_done in RUN, enter DONE, set npu_done=1, and latch core_class into npu_class_predicted at the same edge.
REQ-026 SHALL ignore core_done outside RUN.
REQ-027 SHALL honour both events when write_row and core_done arrive in the same RUN cycle: count increments and the state becomes DONE.
REQ-028 SHALL, on write_row in DONE, start a new image: count=1, npu_done=0, row_overflow_lat_r=0, state=FILL; npu_class_predicted holds its value until the next core_done.
REQ-029 SHALL drive core_row_ready combinationally as (core_row_req < count) while in FILL or RUN, and 1 while in DONE.
REQ-030 SHALL drive img_num_rows_written = count; count never exceeds IMG_ROWS.

Reset
REQ-031 SHALL, while resetn=0, hold state=IDLE, count=0, npu_start=0, npu_active=0, npu_done=0, npu_class_predicted=0, row_overflow_lat_r=0.
REQ-032 SHALL treat reset asserted mid-RUN as aborting the image; no npu_start or done pulse is produced until new rows arrive.

Structure
REQ-033 SHALL place the state enum (row_ctrl_state_t), IMG_ROWS default and class width in shared package npu_pkg; the AHB CSR decoder imports the same package.
REQ-034 SHALL be a single module with no sub-modules; the threshold clamp is a local function.

Verification
REQ-035 SHALL cover: thr=3, three write_row pulses 1 cycle apart -> count 1,2,3; npu_start single pulse 2 edges after the third pulse; npu_active=1.
REQ-036 SHALL cover: thr=0, IMG_ROWS=28 -> no start until the 28th row; thr=40 behaves identically.
REQ-037 SHALL cover: in RUN, core_done with core_class=17 and write_row in the same cycle -> npu_done=1, class=17, count+1, state DONE.
REQ-038 SHALL cover: 29 write_row pulses with thr=28 -> count stays 28 and row_overflow_lat_r=1; the next image's first row clears it.
REQ-039 SHALL cover: core_row_req=5 with count=5 -> core_row_ready=0; after one more write_row -> 1.
REQ-040 SHALL cover: resetn low during RUN with count=10 -> all outputs 0 and state IDLE; core_done after release is ignored.
